// File: rtl/fetch_sched.sv
// Fetch scheduler: drives imem PC, issues one instruction per cycle,
// interlocks RAW hazards with a per-register countdown scoreboard.
module fetch_sched #(
  parameter int          PC_W       = 14,
  parameter int          NREG       = 32,
  parameter int          PIPE_DEPTH = 3,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic [PC_W-1:0] pc,
  input  logic [31:0]     ir,
  input  logic [4:0]      dec_rd,
  input  logic [4:0]      dec_rs1,
  input  logic [4:0]      dec_rs2,
  input  logic            dec_wr_en,
  input  logic            dec_use_rs1,
  input  logic            dec_use_rs2,
  input  logic            dec_is_ctrl,
  input  logic            br_valid,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic            issue_valid,
  output logic [31:0]     issue_ir,
  output logic            stall,
  output logic            err_spurious_br
);

  localparam logic [0:0] S_RUN = 1'b0;
  localparam logic [0:0] S_BRW = 1'b1;

  logic [0:0] state;
  logic [2:0] cnt [NREG];
  logic       haz1;
  logic       haz2;
  logic       hazard;
  logic       issue;
  logic       load;

  assign haz1   = dec_use_rs1 && (dec_rs1 != 5'd0)
                  && (cnt[dec_rs1] != 3'd0);
  assign haz2   = dec_use_rs2 && (dec_rs2 != 5'd0)
                  && (cnt[dec_rs2] != 3'd0);
  assign hazard = haz1 || haz2;
  assign stall  = hazard && (state == S_RUN) && run;
  assign issue  = (state == S_RUN) && run && !hazard;
  assign load   = issue && dec_wr_en;

  // R0 is never loaded, so its counter stays at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        cnt[i] <= 3'd0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (load && (dec_rd == 5'(i))) begin
          cnt[i] <= 3'(PIPE_DEPTH);
        end else if (cnt[i] != 3'd0) begin
          cnt[i] <= cnt[i] - 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_RUN;
      pc              <= '0;
      issue_valid     <= 1'b0;
      issue_ir        <= NOP_WORD;
      err_spurious_br <= 1'b0;
    end else begin
      issue_valid <= 1'b0;
      issue_ir    <= NOP_WORD;
      unique case (state)
        S_RUN: begin
          if (br_valid) begin
            err_spurious_br <= 1'b1;
          end
          if (issue) begin
            issue_valid <= 1'b1;
            issue_ir    <= ir;
            pc          <= pc + PC_W'(1);
            if (dec_is_ctrl) begin
              state <= S_BRW;
            end
          end
        end
        S_BRW: begin
          if (br_valid) begin
            if (br_taken) begin
              pc <= br_target;
            end
            state <= S_RUN;
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sched.sv
// Bench for fetch_sched: directed table, hand corner sequences,
// and a randomized run against a timestamp-based reference model.
module tb_fetch_sched;

  localparam int          PD  = 3;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [13:0] pc;
  logic [31:0] ir;
  logic [4:0]  dec_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic        dec_wr_en;
  logic        dec_use_rs1;
  logic        dec_use_rs2;
  logic        dec_is_ctrl;
  logic        br_valid;
  logic        br_taken;
  logic [13:0] br_target;
  logic        issue_valid;
  logic [31:0] issue_ir;
  logic        stall;
  logic        err_spurious_br;

  logic [31:0] imem [0:16383];

  // instruction word layout: ctrl,wr,use1,use2,rd,rs1,rs2,tag
  assign ir          = imem[pc];
  assign dec_is_ctrl = ir[31];
  assign dec_wr_en   = ir[30];
  assign dec_use_rs1 = ir[29];
  assign dec_use_rs2 = ir[28];
  assign dec_rd      = ir[27:23];
  assign dec_rs1     = ir[22:18];
  assign dec_rs2     = ir[17:13];

  fetch_sched dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .run             (run),
    .pc              (pc),
    .ir              (ir),
    .dec_rd          (dec_rd),
    .dec_rs1         (dec_rs1),
    .dec_rs2         (dec_rs2),
    .dec_wr_en       (dec_wr_en),
    .dec_use_rs1     (dec_use_rs1),
    .dec_use_rs2     (dec_use_rs2),
    .dec_is_ctrl     (dec_is_ctrl),
    .br_valid        (br_valid),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .issue_valid     (issue_valid),
    .issue_ir        (issue_ir),
    .stall           (stall),
    .err_spurious_br (err_spurious_br)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total;
  int   bad;
  logic st_s;

  typedef struct {
    logic        run;
    logic        bv;
    logic        bt;
    logic [13:0] tgt;
    logic        st;
    logic        v;
    logic [13:0] pc;
  } vec_t;

  vec_t tbl [21];

  function automatic logic [31:0] mk(
    input logic c, w, a, b,
    input logic [4:0] rd, r1, r2,
    input int tag);
    return {c, w, a, b, rd, r1, r2, 13'(tag)};
  endfunction

  function automatic vec_t mv(
    input logic r, bv, bt, input int tgt,
    input logic st, v, input int p);
    vec_t x;
    x.run = r; x.bv = bv; x.bt = bt; x.tgt = 14'(tgt);
    x.st = st; x.v = v; x.pc = 14'(p);
    return x;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act, exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // called just after a posedge; returns just after the next one
  task automatic cyc(input logic r, bv, bt, input logic [13:0] tg);
    run = r; br_valid = bv; br_taken = bt; br_target = tg;
    @(negedge clk);
    st_s = stall;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    run = 1'b0; br_valid = 1'b0; br_taken = 1'b0; br_target = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // reference model state
  int          ready [32];
  int          tcyc;
  logic [13:0] mpc;
  logic        mwait;
  logic        merr;

  initial begin
    logic [13:0] prev;
    logic [31:0] w;
    logic        haz;
    logic        est;
    logic        ev;
    logic [31:0] eir;
    logic        r, bv, bt;
    logic [13:0] tg;

    total = 0;
    bad   = 0;
    for (int a = 0; a < 16384; a++) imem[a] = mk(0,0,0,0,0,0,0,a);
    imem[0]  = mk(0,1,0,0, 1, 0,0, 0);
    imem[1]  = mk(0,1,1,1, 5, 5,1, 1);
    imem[2]  = mk(0,1,0,0, 0, 0,0, 2);
    imem[3]  = mk(0,1,1,1, 6, 0,0, 3);
    for (int k = 0; k < 8; k++) imem[4+k] = mk(0,1,0,0,5'(8+k),0,0,4+k);
    imem[12] = mk(1,0,1,0, 0,20,0,12);
    imem[13] = mk(0,1,1,0,16,15,0,13);
    imem[21] = mk(0,1,0,0,17, 0,0,21);
    imem[22] = mk(1,0,0,0, 0, 0,0,22);
    imem[14] = mk(1,0,0,0, 0, 0,0,14);

    tbl[0]  = mv(1,0,0,0, 0,1,1);
    tbl[1]  = mv(1,0,0,0, 1,0,1);
    tbl[2]  = mv(1,0,0,0, 1,0,1);
    tbl[3]  = mv(1,0,0,0, 1,0,1);
    tbl[4]  = mv(1,0,0,0, 0,1,2);
    tbl[5]  = mv(1,0,0,0, 0,1,3);
    tbl[6]  = mv(1,0,0,0, 0,1,4);
    tbl[7]  = mv(0,0,0,0, 0,0,4);
    for (int k = 0; k < 8; k++) tbl[8+k] = mv(1,0,0,0, 0,1,5+k);
    tbl[16] = mv(1,0,0,0, 0,1,13);
    tbl[17] = mv(1,0,0,0, 0,0,13);
    tbl[18] = mv(0,0,0,0, 0,0,13);
    tbl[19] = mv(1,1,1,21, 0,0,21);
    tbl[20] = mv(1,0,0,0, 0,1,22);

    rst_n = 1'b0;
    run = 1'b0; br_valid = 1'b0; br_taken = 1'b0; br_target = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_valid", 32'(issue_valid), 32'd0);
    chk("rst_ir", issue_ir, NOP);
    chk("rst_err", 32'(err_spurious_br), 32'd0);
    rst_n = 1'b1;

    prev = '0;
    for (int i = 0; i < 21; i++) begin
      cyc(tbl[i].run, tbl[i].bv, tbl[i].bt, tbl[i].tgt);
      chk($sformatf("tbl%0d_stall", i), 32'(st_s), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_valid", i), 32'(issue_valid), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_pc", i), 32'(pc), 32'(tbl[i].pc));
      chk($sformatf("tbl%0d_ir", i), issue_ir,
          tbl[i].v ? imem[prev] : NOP);
      prev = tbl[i].pc;
    end

    // jump back to 12, then not-taken resolution of that BZ
    cyc(1,0,0,0);
    cyc(1,1,1,14'd12);
    chk("nt_jmp_pc", 32'(pc), 32'd12);
    cyc(1,0,0,0);
    chk("nt_bz_ir", issue_ir, imem[12]);
    cyc(1,0,0,0);
    cyc(1,0,0,0);
    cyc(1,1,0,14'd999);
    chk("nt_hold_pc", 32'(pc), 32'd13);
    chk("nt_hold_v", 32'(issue_valid), 32'd0);
    cyc(1,0,0,0);
    chk("nt_ft_ir", issue_ir, imem[13]);
    chk("nt_ft_pc", 32'(pc), 32'd14);

    // wrap from the top of memory
    cyc(1,0,0,0);
    cyc(1,1,1,14'd16383);
    chk("wrap_tgt", 32'(pc), 32'd16383);
    cyc(1,0,0,0);
    chk("wrap_pc", 32'(pc), 32'd0);
    chk("wrap_ir", issue_ir, imem[16383]);

    // reset while waiting on a branch with R3 still busy
    imem[0] = mk(0,1,0,0,3,0,0,0);
    imem[1] = mk(1,0,0,0,0,0,0,1);
    do_reset();
    cyc(1,0,0,0);
    cyc(1,0,0,0);
    chk("mid_pc_pre", 32'(pc), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pc", 32'(pc), 32'd0);
    chk("mid_rst_v", 32'(issue_valid), 32'd0);
    chk("mid_rst_ir", issue_ir, NOP);
    chk("mid_rst_err", 32'(err_spurious_br), 32'd0);
    imem[0] = mk(0,1,1,1,4,3,3,0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1,0,0,0);
    chk("r3_stall", 32'(st_s), 32'd0);
    chk("r3_valid", 32'(issue_valid), 32'd1);
    chk("r3_pc", 32'(pc), 32'd1);

    // resolution arriving in the same cycle the control issues
    cyc(1,1,1,14'd100);
    chk("sp_err", 32'(err_spurious_br), 32'd1);
    chk("sp_pc", 32'(pc), 32'd2);
    chk("sp_valid", 32'(issue_valid), 32'd1);
    cyc(1,1,0,0);
    chk("sp_res_pc", 32'(pc), 32'd2);
    cyc(1,0,0,0);
    chk("sp_sticky", 32'(err_spurious_br), 32'd1);
    chk("sp_next_pc", 32'(pc), 32'd3);

    // randomized program and stimulus against the model
    for (int a = 0; a < 16384; a++) begin
      imem[a] = mk($urandom_range(0,7) == 0, 1'($urandom),
                   1'($urandom), 1'($urandom),
                   5'($urandom_range(0,7)), 5'($urandom_range(0,7)),
                   5'($urandom_range(0,7)), int'($urandom));
    end
    do_reset();
    for (int k = 0; k < 32; k++) ready[k] = 0;
    tcyc  = 1;
    mpc   = '0;
    mwait = 1'b0;
    merr  = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0,9) != 0);
      bv = mwait && ($urandom_range(0,2) == 0);
      bt = 1'($urandom);
      tg = 14'($urandom);
      w  = imem[mpc];
      haz = (w[29] && w[22:18] != 0 && tcyc < ready[w[22:18]])
         || (w[28] && w[17:13] != 0 && tcyc < ready[w[17:13]]);
      est = !mwait && r && haz;
      ev  = 1'b0;
      eir = NOP;
      if (!mwait) begin
        if (bv) merr = 1'b1;
        if (r && !haz) begin
          ev  = 1'b1;
          eir = w;
          mpc = 14'((int'(mpc) + 1) % 16384);
          if (w[30] && w[27:23] != 0) ready[w[27:23]] = tcyc + PD + 1;
          if (w[31]) mwait = 1'b1;
        end
      end else if (bv) begin
        if (bt) mpc = tg;
        mwait = 1'b0;
      end
      cyc(r, bv, bt, tg);
      chk("rnd_stall", 32'(st_s), 32'(est));
      chk("rnd_valid", 32'(issue_valid), 32'(ev));
      chk("rnd_ir", issue_ir, eir);
      chk("rnd_pc", 32'(pc), 32'(mpc));
      chk("rnd_err", 32'(err_spurious_br), 32'(merr));
      tcyc++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
